// File: rtl/fetch_seq_pkg.sv
// Shared Y86-64 fetch definitions: icodes, instruction lengths and fetch FSM states.
// FETCH_ILLEGAL_TRAP_EN adds the ERROR state used to trap illegal icodes.
package fetch_seq_pkg;

   localparam int unsigned FETCH_DATA_WID = 64;
   localparam int unsigned INST_MAX_BYTES = 10;

   localparam logic [3:0] ICODE_HALT   = 4'h0;
   localparam logic [3:0] ICODE_NOP    = 4'h1;
   localparam logic [3:0] ICODE_RRMOV  = 4'h2;
   localparam logic [3:0] ICODE_CMOVXX = 4'h2;
   localparam logic [3:0] ICODE_IRMOV  = 4'h3;
   localparam logic [3:0] ICODE_RMMOV  = 4'h4;
   localparam logic [3:0] ICODE_MRMOV  = 4'h5;
   localparam logic [3:0] ICODE_OP     = 4'h6;
   localparam logic [3:0] ICODE_JXX    = 4'h7;
   localparam logic [3:0] ICODE_CALL   = 4'h8;
   localparam logic [3:0] ICODE_RET    = 4'h9;
   localparam logic [3:0] ICODE_PUSH   = 4'hA;
   localparam logic [3:0] ICODE_POP    = 4'hB;

   localparam logic [3:0] LEN_1  = 4'd1;
   localparam logic [3:0] LEN_2  = 4'd2;
   localparam logic [3:0] LEN_9  = 4'd9;
   localparam logic [3:0] LEN_10 = 4'd10;

   typedef enum logic [2:0] {
      ST_FETCH0  = 3'd0,
      ST_FETCHN  = 3'd1,
      ST_PRESENT = 3'd2,
      ST_HALTED  = 3'd3
`ifdef FETCH_ILLEGAL_TRAP_EN
      ,
      ST_ERROR   = 3'd4
`endif
   } fetch_state_e;

   function automatic logic icode_is_halt(input logic [3:0] icode);
      return icode == ICODE_HALT;
   endfunction

endpackage

// File: rtl/fetch_seq_icode.sv
// Combinational icode -> instruction length decoder, shared by fetch and decode.
// Illegal icodes (C..F) report legal = 0 with a nominal length of one byte.
module icode_len
   import fetch_seq_pkg::*;
(
   input  logic [3:0] icode,
   output logic [3:0] len,
   output logic       legal
);

   always_comb begin
      len   = LEN_1;
      legal = 1'b1;
      case (icode)
         ICODE_HALT, ICODE_NOP, ICODE_RET:              len = LEN_1;
         ICODE_RRMOV, ICODE_OP, ICODE_PUSH, ICODE_POP: len = LEN_2;
         ICODE_JXX, ICODE_CALL:                         len = LEN_9;
         ICODE_IRMOV, ICODE_RMMOV, ICODE_MRMOV:         len = LEN_10;
         default: begin
            len   = LEN_1;
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/fetch_seq.sv
// Byte-serial Y86-64 instruction fetch sequencer owning the architectural PC.
// Build option FETCH_ILLEGAL_TRAP_EN: trap illegal icodes into ERROR instead of presenting them.
module fetch_seq
   import fetch_seq_pkg::*;
#(
   parameter int unsigned         DATA_WID = FETCH_DATA_WID,
   parameter logic [DATA_WID-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   output logic                imem_req,
   output logic [DATA_WID-1:0] imem_addr,
   input  logic                imem_ack,
   input  logic [7:0]          imem_rdata,
   output logic                inst_valid,
   input  logic                inst_ready,
   output logic [79:0]         inst_bytes,
   output logic [DATA_WID-1:0] inst_pc,
   output logic [DATA_WID-1:0] inst_valP,
   input  logic                redirect_en,
   input  logic [DATA_WID-1:0] redirect_pc,
   output logic                halted,
   output logic                inst_err
);

   fetch_state_e        state_reg, state_next;
   logic [DATA_WID-1:0] pc_reg, pc_next;
   logic [DATA_WID-1:0] valp_reg, valp_next;
   logic [DATA_WID-1:0] pend_pc_reg, pend_pc_next;
   logic [3:0]          idx_reg, idx_next;
   logic [3:0]          len_reg, len_next;
   logic                pend_reg, pend_next;

   logic                req_int;
   logic                byte_we;
   logic                buf_clr;
   logic [79:0]         buf_bytes;
   logic [3:0]          dec_len;
   logic                dec_legal;
   logic [3:0]          fetch_len;
   logic                present;

   icode_len u_icode_len (
      .icode (imem_rdata[7:4]),
      .len   (dec_len),
      .legal (dec_legal)
   );

   // Illegal icodes fall back to one byte so the sequencer never stalls on them.
   assign fetch_len = dec_legal ? dec_len : LEN_1;

   genvar gi;
   generate
      for (gi = 0; gi < INST_MAX_BYTES; gi++) begin : g_lane
         logic [7:0] byte_reg;
         always_ff @(posedge clk) begin
            if (rst || buf_clr) begin
               byte_reg <= 8'h00;
            end else if (byte_we && (idx_reg == 4'(gi))) begin
               byte_reg <= imem_rdata;
            end
         end
         assign buf_bytes[gi*8 +: 8] = byte_reg;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_FETCH0;
         pc_reg      <= RESET_PC;
         valp_reg    <= '0;
         pend_pc_reg <= '0;
         idx_reg     <= 4'd0;
         len_reg     <= 4'd0;
         pend_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         pc_reg      <= pc_next;
         valp_reg    <= valp_next;
         pend_pc_reg <= pend_pc_next;
         idx_reg     <= idx_next;
         len_reg     <= len_next;
         pend_reg    <= pend_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      pc_next      = pc_reg;
      valp_next    = valp_reg;
      pend_pc_next = pend_pc_reg;
      idx_next     = idx_reg;
      len_next     = len_reg;
      pend_next    = pend_reg;
      req_int      = 1'b0;
      byte_we      = 1'b0;
      buf_clr      = 1'b0;
      case (state_reg)
         ST_FETCH0, ST_FETCHN: begin
            req_int = 1'b1;
            if (!imem_ack) begin
               // A redirect cannot abandon an unanswered request; park it until the ack.
               if (redirect_en) begin
                  pend_next    = 1'b1;
                  pend_pc_next = redirect_pc;
               end
            end else if (redirect_en || pend_reg) begin
               pc_next    = redirect_en ? redirect_pc : pend_pc_reg;
               pend_next  = 1'b0;
               idx_next   = 4'd0;
               buf_clr    = 1'b1;
               state_next = ST_FETCH0;
            end else begin
               byte_we  = 1'b1;
               idx_next = idx_reg + 4'd1;
               if (state_reg == ST_FETCH0) begin
                  len_next  = fetch_len;
                  valp_next = icode_is_halt(imem_rdata[7:4]) ? pc_reg
                            : pc_reg + {{(DATA_WID-4){1'b0}}, fetch_len};
`ifdef FETCH_ILLEGAL_TRAP_EN
                  if (!dec_legal) begin
                     state_next = ST_ERROR;
                  end else
`endif
                  if (fetch_len == LEN_1) begin
                     state_next = ST_PRESENT;
                  end else begin
                     state_next = ST_FETCHN;
                  end
               end else if (idx_reg == len_reg - 4'd1) begin
                  state_next = ST_PRESENT;
               end
            end
         end
         ST_PRESENT: begin
            if (redirect_en) begin
               pc_next    = redirect_pc;
               idx_next   = 4'd0;
               buf_clr    = 1'b1;
               state_next = ST_FETCH0;
            end else if (inst_ready) begin
               pc_next    = valp_reg;
               idx_next   = 4'd0;
               buf_clr    = 1'b1;
               state_next = icode_is_halt(buf_bytes[7:4]) ? ST_HALTED : ST_FETCH0;
            end
         end
         default: begin
            if (redirect_en) begin
               pc_next    = redirect_pc;
               idx_next   = 4'd0;
               buf_clr    = 1'b1;
               state_next = ST_FETCH0;
            end
         end
      endcase
   end

   assign present    = (state_reg == ST_PRESENT);
   assign imem_req   = req_int & ~rst;
   assign imem_addr  = pc_reg + {{(DATA_WID-4){1'b0}}, idx_reg};
   assign inst_valid = present;
   assign inst_bytes = present ? buf_bytes : 80'd0;
   assign inst_pc    = present ? pc_reg : '0;
   assign inst_valP  = present ? valp_reg : '0;
   assign halted     = (state_reg == ST_HALTED);
`ifdef FETCH_ILLEGAL_TRAP_EN
   assign inst_err   = (state_reg == ST_ERROR);
`else
   assign inst_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: latency-programmable byte memory plus expected-instruction queue.
module tb_fetch_seq;

   typedef struct {
      logic [63:0] pc;
      logic [63:0] valp;
      logic [79:0] bytes;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack;
   logic [7:0]  imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [79:0] inst_bytes;
   logic [63:0] inst_pc;
   logic [63:0] inst_valP;
   logic        redirect_en;
   logic [63:0] redirect_pc;
   logic        halted;
   logic        inst_err;

   logic [7:0]  mem [4096];
   int          lat;
   int          wait_cnt;
   exp_t        exp_q[$];
   exp_t        e;
   int          chk_cnt;
   int          pass_cnt;

   fetch_seq #(.DATA_WID(64), .RESET_PC(64'h100)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst_bytes  (inst_bytes),
      .inst_pc     (inst_pc),
      .inst_valP   (inst_valP),
      .redirect_en (redirect_en),
      .redirect_pc (redirect_pc),
      .halted      (halted),
      .inst_err    (inst_err)
   );

   always #5 clk = ~clk;

   assign imem_ack   = imem_req && (wait_cnt >= lat);
   assign imem_rdata = imem_ack ? mem[imem_addr[11:0]] : 8'h00;

   always @(posedge clk) begin
      if (rst) wait_cnt <= 0;
      else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
   end

   always @(negedge clk) begin
      if (inst_valid && inst_ready)
         $display("accept pc=%h valP=%h bytes=%h", inst_pc, inst_valP, inst_bytes);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [79:0] b;
      rst = 1'b1;
      repeat (3) step();
      chk_cnt++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0 || halted !== 1'b0 || inst_err !== 1'b0) begin
         $display("FAIL reset_ctrl: req=%b valid=%b halted=%b err=%b, expected all 0", imem_req, inst_valid, halted, inst_err);
      end else pass_cnt++;
      chk_cnt++;
      if (inst_bytes !== 80'd0 || inst_pc !== 64'd0 || inst_valP !== 64'd0) begin
         $display("FAIL reset_data: bytes=%h pc=%h valP=%h, expected zeros", inst_bytes, inst_pc, inst_valP);
      end else pass_cnt++;
      // irmov at 0x100: 30 F3 then eight immediate bytes
      b = '0;
      mem[12'h100] = 8'h30; b[7:0]  = 8'h30;
      mem[12'h101] = 8'hF3; b[15:8] = 8'hF3;
      for (int k = 0; k < 8; k++) begin
         mem[12'h102 + k] = 8'h11 + 8'(k);
         b[16 + 8*k +: 8] = 8'h11 + 8'(k);
      end
      exp_q.push_back('{pc: 64'h100, valp: 64'h10A, bytes: b});
      rst = 1'b0;
      #1;
      for (int c = 0; c < 10; c++) begin
         chk_cnt++;
         if (imem_req !== 1'b1 || imem_addr !== 64'h100 + 64'(c) || inst_valid !== 1'b0) begin
            $display("FAIL irmov_fetch%0d: req=%b addr=%h valid=%b, expected req=1 addr=%h valid=0", c, imem_req, imem_addr, inst_valid, 64'h100 + 64'(c));
         end else pass_cnt++;
         step();
      end
      chk_cnt++;
      if (inst_valid !== 1'b1 || imem_req !== 1'b0) begin
         $display("FAIL irmov_valid_cycle11: valid=%b req=%b, expected valid=1 req=0", inst_valid, imem_req);
      end else pass_cnt++;
      e = exp_q.pop_front();
      chk_cnt++;
      if (inst_pc !== e.pc || inst_valP !== e.valp || inst_bytes !== e.bytes) begin
         $display("FAIL irmov_inst: pc=%h valP=%h bytes=%h, expected pc=%h valP=%h bytes=%h", inst_pc, inst_valP, inst_bytes, e.pc, e.valp, e.bytes);
      end else pass_cnt++;
      inst_ready = 1'b1;
   endtask

   task automatic test_sequence();
      int cyc = 0;
      int last_valid = 0;
      int n = 0;
      mem[12'h10A] = 8'h10;
      mem[12'h10B] = 8'h60;
      mem[12'h10C] = 8'h23;
      mem[12'h10D] = 8'h00;
      exp_q.push_back('{pc: 64'h10A, valp: 64'h10B, bytes: 80'h10});
      exp_q.push_back('{pc: 64'h10B, valp: 64'h10D, bytes: 80'h2360});
      exp_q.push_back('{pc: 64'h10D, valp: 64'h10D, bytes: 80'h00});
      while (exp_q.size() > 0 && cyc < 40) begin
         step();
         cyc++;
         if (inst_valid) begin
            e = exp_q.pop_front();
            chk_cnt++;
            if (inst_pc !== e.pc || inst_valP !== e.valp || inst_bytes !== e.bytes) begin
               $display("FAIL seq_inst%0d: pc=%h valP=%h bytes=%h, expected pc=%h valP=%h bytes=%h", n, inst_pc, inst_valP, inst_bytes, e.pc, e.valp, e.bytes);
            end else pass_cnt++;
            if (n == 1) begin
               chk_cnt++;
               if (cyc - last_valid !== 3) begin
                  $display("FAIL seq_throughput: gap=%0d cycles, expected 3", cyc - last_valid);
               end else pass_cnt++;
            end
            last_valid = cyc;
            n++;
         end
      end
      chk_cnt++;
      if (n !== 3) begin
         $display("FAIL seq_count: presented=%0d, expected 3", n);
         exp_q.delete();
      end else pass_cnt++;
      step();
      chk_cnt++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
         $display("FAIL halt_state: halted=%b req=%b valid=%b, expected 1 0 0", halted, imem_req, inst_valid);
      end else pass_cnt++;
      inst_ready = 1'b0;
      repeat (3) step();
      chk_cnt++;
      if (halted !== 1'b1 || imem_req !== 1'b0) begin
         $display("FAIL halt_hold: halted=%b req=%b, expected 1 0", halted, imem_req);
      end else pass_cnt++;
   endtask

   task automatic test_stall();
      int cyc = 0;
      mem[12'h300] = 8'h20;
      mem[12'h301] = 8'h12;
      exp_q.push_back('{pc: 64'h300, valp: 64'h302, bytes: 80'h1220});
      redirect_pc = 64'h300;
      redirect_en = 1'b1;
      step();
      redirect_en = 1'b0;
      chk_cnt++;
      if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h300) begin
         $display("FAIL halt_exit: halted=%b req=%b addr=%h, expected 0 1 300", halted, imem_req, imem_addr);
      end else pass_cnt++;
      while (!inst_valid && cyc < 20) begin
         step();
         cyc++;
      end
      e = exp_q.pop_front();
      for (int c = 0; c < 5; c++) begin
         chk_cnt++;
         if (inst_valid !== 1'b1 || imem_req !== 1'b0 || inst_pc !== e.pc || inst_valP !== e.valp || inst_bytes !== e.bytes) begin
            $display("FAIL stall_hold%0d: valid=%b req=%b pc=%h valP=%h bytes=%h, expected 1 0 %h %h %h", c, inst_valid, imem_req, inst_pc, inst_valP, inst_bytes, e.pc, e.valp, e.bytes);
         end else pass_cnt++;
         step();
      end
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      chk_cnt++;
      if (inst_valid !== 1'b0 || imem_addr !== 64'h302) begin
         $display("FAIL stall_release: valid=%b addr=%h, expected 0 302", inst_valid, imem_addr);
      end else pass_cnt++;
   endtask

   task automatic test_pending_redirect();
      int cyc = 0;
      while (!inst_valid && cyc < 20) begin
         step();
         cyc++;
      end
      lat = 3;
      mem[12'h400] = 8'h60;
      mem[12'h200] = 8'h10;
      exp_q.push_back('{pc: 64'h200, valp: 64'h201, bytes: 80'h10});
      redirect_pc = 64'h400;
      redirect_en = 1'b1;
      step();
      redirect_en = 1'b0;
      chk_cnt++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h400 || imem_ack !== 1'b0) begin
         $display("FAIL pend_wait1: req=%b addr=%h ack=%b, expected 1 400 0", imem_req, imem_addr, imem_ack);
      end else pass_cnt++;
      step();
      redirect_pc = 64'h500;
      redirect_en = 1'b1;
      step();
      redirect_pc = 64'h200;
      chk_cnt++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h400) begin
         $display("FAIL pend_hold: req=%b addr=%h, expected 1 400", imem_req, imem_addr);
      end else pass_cnt++;
      step();
      redirect_en = 1'b0;
      chk_cnt++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h400 || imem_ack !== 1'b1) begin
         $display("FAIL pend_ack: req=%b addr=%h ack=%b, expected 1 400 1", imem_req, imem_addr, imem_ack);
      end else pass_cnt++;
      step();
      chk_cnt++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h200) begin
         $display("FAIL pend_target: req=%b addr=%h, expected 1 200", imem_req, imem_addr);
      end else pass_cnt++;
      cyc = 0;
      while (!inst_valid && cyc < 20) begin
         step();
         cyc++;
      end
      e = exp_q.pop_front();
      chk_cnt++;
      if (inst_valid !== 1'b1 || inst_pc !== e.pc || inst_valP !== e.valp || inst_bytes !== e.bytes) begin
         $display("FAIL pend_inst: valid=%b pc=%h valP=%h bytes=%h, expected 1 %h %h %h", inst_valid, inst_pc, inst_valP, inst_bytes, e.pc, e.valp, e.bytes);
      end else pass_cnt++;
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      lat = 0;
   endtask

   task automatic test_wrap();
      int cyc = 0;
      while (!inst_valid && cyc < 20) begin
         step();
         cyc++;
      end
      mem[12'hFFE] = 8'h61;
      mem[12'hFFF] = 8'h23;
      exp_q.push_back('{pc: 64'hFFFF_FFFF_FFFF_FFFE, valp: 64'h0, bytes: 80'h2361});
      redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
      redirect_en = 1'b1;
      step();
      redirect_en = 1'b0;
      chk_cnt++;
      if (imem_req !== 1'b1 || imem_addr !== 64'hFFFF_FFFF_FFFF_FFFE) begin
         $display("FAIL wrap_addr0: req=%b addr=%h, expected 1 fffffffffffffffe", imem_req, imem_addr);
      end else pass_cnt++;
      step();
      chk_cnt++;
      if (imem_req !== 1'b1 || imem_addr !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         $display("FAIL wrap_addr1: req=%b addr=%h, expected 1 ffffffffffffffff", imem_req, imem_addr);
      end else pass_cnt++;
      step();
      e = exp_q.pop_front();
      chk_cnt++;
      if (inst_valid !== 1'b1 || inst_pc !== e.pc || inst_valP !== e.valp || inst_bytes !== e.bytes) begin
         $display("FAIL wrap_inst: valid=%b pc=%h valP=%h bytes=%h, expected 1 %h %h %h", inst_valid, inst_pc, inst_valP, inst_bytes, e.pc, e.valp, e.bytes);
      end else pass_cnt++;
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      chk_cnt++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
         $display("FAIL wrap_next: req=%b addr=%h, expected 1 0", imem_req, imem_addr);
      end else pass_cnt++;
   endtask

   task automatic test_illegal();
      int cyc = 0;
      while (!inst_valid && cyc < 20) begin
         step();
         cyc++;
      end
      mem[12'h600] = 8'hC0;
`ifndef FETCH_ILLEGAL_TRAP_EN
      exp_q.push_back('{pc: 64'h600, valp: 64'h601, bytes: 80'hC0});
`endif
      // The presented instruction is a HALT; the redirect must beat the accept.
      inst_ready  = 1'b1;
      redirect_pc = 64'h600;
      redirect_en = 1'b1;
      step();
      inst_ready  = 1'b0;
      redirect_en = 1'b0;
      chk_cnt++;
      if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h600) begin
         $display("FAIL redirect_wins: halted=%b req=%b addr=%h, expected 0 1 600", halted, imem_req, imem_addr);
      end else pass_cnt++;
      step();
`ifdef FETCH_ILLEGAL_TRAP_EN
      for (int c = 0; c < 3; c++) begin
         chk_cnt++;
         if (inst_err !== 1'b1 || inst_valid !== 1'b0 || imem_req !== 1'b0) begin
            $display("FAIL trap_state%0d: err=%b valid=%b req=%b, expected 1 0 0", c, inst_err, inst_valid, imem_req);
         end else pass_cnt++;
         step();
      end
      redirect_pc = 64'h200;
      redirect_en = 1'b1;
      step();
      redirect_en = 1'b0;
      chk_cnt++;
      if (inst_err !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h200) begin
         $display("FAIL trap_exit: err=%b req=%b addr=%h, expected 0 1 200", inst_err, imem_req, imem_addr);
      end else pass_cnt++;
`else
      e = exp_q.pop_front();
      chk_cnt++;
      if (inst_valid !== 1'b1 || inst_err !== 1'b0 || inst_pc !== e.pc || inst_valP !== e.valp || inst_bytes !== e.bytes) begin
         $display("FAIL illegal_inst: valid=%b err=%b pc=%h valP=%h bytes=%h, expected 1 0 %h %h %h", inst_valid, inst_err, inst_pc, inst_valP, inst_bytes, e.pc, e.valp, e.bytes);
      end else pass_cnt++;
`endif
   endtask

   initial begin
      chk_cnt     = 0;
      pass_cnt    = 0;
      lat         = 0;
      rst         = 1'b1;
      inst_ready  = 1'b0;
      redirect_en = 1'b0;
      redirect_pc = 64'h0;
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      test_reset();
      test_sequence();
      test_stall();
      test_pending_redirect();
      test_wrap();
      test_illegal();
      chk_cnt++;
      if (exp_q.size() !== 0) begin
         $display("FAIL scoreboard_drain: left=%0d, expected 0", exp_q.size());
      end else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Multi-cycle instruction fetch sequencer for the Y86-64 core. Fetches instruction bytes one at a time from a byte-wide instruction memory over a req/ack handshake and decodes the length from the icode. Presents the assembled instruction, its PC and its fall-through PC (valP) to decode over a valid/ready handshake. Owns the architectural PC: advances it to valP, or loads it from an execute-stage redirect (jXX taken, call, ret).

## Interface
Parameters:
- DATA_WID, 64, PC/address width
- RESET_PC, 0, PC value loaded on reset

Ports (clock and reset first):
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- imem_req  out  1  byte read request
- imem_addr  out  DATA_WID  byte address
- imem_ack  in  1  read data valid this cycle (may be same cycle as req)
- imem_rdata  in  8  read byte
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode accepts instruction
- inst_bytes  out  80  instruction bytes, byte 0 in [7:0], unused bytes zero
- inst_pc  out  DATA_WID  PC of presented instruction
- inst_valP  out  DATA_WID  fall-through PC
- redirect_en  in  1  load new PC
- redirect_pc  in  DATA_WID  redirect target
- halted  out  1  fetch stopped on HALT
- inst_err  out  1  illegal icode trapped (see Configuration)

## Operation
- States: FETCH0 (request byte 0), FETCHN (bytes 1..len-1), PRESENT (inst_valid high), HALTED, ERROR.
- Length from icode = byte0[7:4]: 0,1,9 -> 1; 2,6,A,B -> 2; 7,8 -> 9; 3,4,5 -> 10; C..F illegal.
- valP = PC + len, except HALT: valP = PC. Addition modulo 2^DATA_WID (wraps).
- FETCH0/FETCHN: imem_req high, imem_addr = PC + byte index; each ack stores byte at index, index++. After last byte: PRESENT.
- PRESENT: hold all inst_* stable until inst_ready. On accept: PC <= inst_valP; next state FETCH0, or HALTED if icode = HALT.
- HALTED/ERROR: imem_req low, inst_valid low; halted / inst_err high. Left only by redirect or reset.
- Redirect (any state): PC <= redirect_pc, buffer cleared, next state FETCH0. Exception: if imem_req is high and imem_ack low, redirect is latched as pending; req held until ack, the byte is discarded, then the pending PC is loaded and FETCH0 entered. A second redirect while pending overwrites the target.
- Redirect and inst_ready in the same PRESENT cycle: redirect wins, instruction counted as accepted, PC <= redirect_pc.

## Timing
- Reset: PC = RESET_PC, state FETCH0; imem_req, inst_valid, halted, inst_err = 0; inst_bytes/inst_pc/inst_valP = 0. imem_req rises the first cycle after rst deasserts.
- Zero-wait memory (ack same cycle as req): len-byte instruction takes len cycles; inst_valid rises the cycle after the last ack.
- Minimum throughput: len + 1 cycles per instruction (accept cycle + len fetch cycles).
- imem_req never drops without ack; imem_addr stable while req high and ack low.
- rst mid-fetch aborts immediately; outstanding memory request is abandoned. Memory side must tolerate this.

## Configuration
- FETCH_ILLEGAL_TRAP_EN defined: illegal icode (C..F) enters ERROR after byte 0, inst_err = 1, no instruction presented.
- Undefined: illegal icode treated as 1-byte NOP-length instruction and presented normally (valP = PC + 1); inst_err tied 0; ERROR state not built.

## Structure
- Shared header: icode constants (_HALT, _NOP, _RRMOV/_CMOVXX, _IRMOV, _RMMOV, _MRMOV, _OP, _JXX, _CALL, _RET, _PUSH, _POP), DATA_WID, length constants (1/2/9/10), state encodings.
- One sub-module: icode_len (combinational icode -> 4-bit length + legal flag), reusable by decode.

## Test plan
- Reset with RESET_PC=0x100, zero-wait memory holding 0x30 F3 + 8 imm bytes (irmov) -> addrs 0x100..0x109 requested, inst_valid on cycle 11, inst_valP = 0x10A.
- Sequence 0x10 (nop), 0x60 0x23 (addq), 0x00 (halt) with inst_ready tied 1 -> valP 1, 3, 3; halted = 1 after halt accepted, imem_req stays 0.
- inst_ready held low 5 cycles in PRESENT -> inst_* stable, no further imem_req.
- Memory with 3-cycle ack latency, redirect_en to 0x200 in 2nd wait cycle of byte 0 -> req held until ack, byte discarded, next imem_addr = 0x200.
- PC = 2^64-2, fetch 2-byte instruction -> addrs wrap to 0, inst_valP = 0.
- Byte 0 = 0xC0: with FETCH_ILLEGAL_TRAP_EN -> inst_err = 1, inst_valid never set; without -> presented, inst_valP = PC + 1.
